fetch_queue: RTL and testbench

Decoupling buffer between the fetch stage and decode. It accepts one fetch packet per cycle: `FETCH_WIDTH` instructions, with the per-lane taken predictions and the predicted next PC produced alongside them by the branch predictor. Packets are stored in FIFO order and presented to decode through a valid/ready handshake. A mispredict flush discards all buffered wrong-path packets.

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode packet handshake bundle for fetch_queue
interface fetch_queue_if #(
    parameter int FETCH_WIDTH = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_pc;
    logic [FETCH_WIDTH*32-1:0] in_insts;
    logic [FETCH_WIDTH-1:0]    in_inst_valid;
    logic [FETCH_WIDTH-1:0]    in_pred_taken;
    logic [31:0]               in_next_pc;

    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_pc;
    logic [FETCH_WIDTH*32-1:0] out_insts;
    logic [FETCH_WIDTH-1:0]    out_inst_valid;
    logic [FETCH_WIDTH-1:0]    out_pred_taken;
    logic [31:0]               out_next_pc;

    modport master (
        output in_valid, in_pc, in_insts, in_inst_valid, in_pred_taken, in_next_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_insts, out_inst_valid, out_pred_taken, out_next_pc
    );

    modport slave (
        input  in_valid, in_pc, in_insts, in_inst_valid, in_pred_taken, in_next_pc, out_ready,
        output in_ready, out_valid, out_pc, out_insts, out_inst_valid, out_pred_taken, out_next_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch packet FIFO between fetch and decode with taken-lane masking and flush
module fetch_queue #(
    parameter int FETCH_WIDTH = 4,
    parameter int DEPTH       = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    fetch_queue_if.slave                 fq,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic [31:0]                 pc_mem    [DEPTH];
    logic [FETCH_WIDTH*32-1:0]   insts_mem [DEPTH];
    logic [FETCH_WIDTH-1:0]      iv_mem    [DEPTH];
    logic [FETCH_WIDTH-1:0]      pt_mem    [DEPTH];
    logic [31:0]                 npc_mem   [DEPTH];

    logic                        empty, full;
    logic                        enq, enq_wr, deq;
    logic                        found;
    logic [FETCH_WIDTH-1:0]      masked_iv, masked_pt;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);

    assign fq.in_ready       = ~full;
    assign fq.out_valid      = ~empty;
    assign fq.out_pc         = pc_mem[rd_ptr[IW-1:0]];
    assign fq.out_insts      = insts_mem[rd_ptr[IW-1:0]];
    assign fq.out_inst_valid = iv_mem[rd_ptr[IW-1:0]];
    assign fq.out_pred_taken = pt_mem[rd_ptr[IW-1:0]];
    assign fq.out_next_pc    = npc_mem[rd_ptr[IW-1:0]];

    // Lanes after the first valid predicted-taken lane are wrong-path and get dropped.
    always_comb begin
        masked_iv = fq.in_inst_valid;
        masked_pt = '0;
        found     = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (found) begin
                masked_iv[i] = 1'b0;
            end else if (fq.in_pred_taken[i] && fq.in_inst_valid[i]) begin
                found        = 1'b1;
                masked_pt[i] = 1'b1;
            end
        end
    end

    assign enq    = fq.in_valid & ~full & ~flush;
    assign enq_wr = enq & (|masked_iv);
    assign deq    = ~empty & fq.out_ready & ~flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                insts_mem[i] <= '0;
                iv_mem[i]    <= '0;
                pt_mem[i]    <= '0;
                npc_mem[i]   <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_wr) begin
                pc_mem[wr_ptr[IW-1:0]]    <= fq.in_pc;
                insts_mem[wr_ptr[IW-1:0]] <= fq.in_insts;
                iv_mem[wr_ptr[IW-1:0]]    <= masked_iv;
                pt_mem[wr_ptr[IW-1:0]]    <= masked_pt;
                npc_mem[wr_ptr[IW-1:0]]   <= fq.in_next_pc;
                wr_ptr                    <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq_wr, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;
    localparam int FW    = 4;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0]      pc;
        logic [FW*32-1:0] insts;
        logic [FW-1:0]    iv;
        logic [FW-1:0]    pt;
        logic [31:0]      npc;
    } pkt_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] count;
    int         checks = 0;
    int         errors = 0;
    pkt_t       q[$];

    fetch_queue_if #(.FETCH_WIDTH(FW)) fq ();

    fetch_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .fq    (fq),
        .count (count)
    );

    always #5 clock = ~clock;

    function automatic pkt_t mk(input logic [31:0] pc, input logic [3:0] iv, input logic [3:0] pt);
        pkt_t p;
        p.pc    = pc;
        p.insts = {pc ^ 32'hDEAD0003, pc ^ 32'hBEEF0002, pc ^ 32'h12340001, pc ^ 32'hA5A50000};
        p.iv    = iv;
        p.pt    = pt;
        p.npc   = pc + 32'h10;
        return p;
    endfunction

    // Reference for what the queue should store for an offered packet.
    function automatic pkt_t stored(input pkt_t p);
        pkt_t r;
        int   f;
        logic [3:0] keep;
        r = p;
        f = -1;
        for (int j = FW - 1; j >= 0; j--)
            if (p.pt[j] && p.iv[j]) f = j;
        if (f < 0) begin
            r.pt = 4'b0000;
        end else begin
            keep = 4'b0000;
            for (int j = 0; j <= f; j++) keep[j] = 1'b1;
            r.iv = p.iv & keep;
            r.pt = 4'b0001 << f;
        end
        return r;
    endfunction

    function automatic pkt_t head();
        return {fq.out_pc, fq.out_insts, fq.out_inst_valid, fq.out_pred_taken, fq.out_next_pc};
    endfunction

    task automatic tick(input bit enq, input pkt_t p, input bit deq, input bit fl);
        bit was_full, was_empty;
        pkt_t s;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        fq.in_valid      = enq;
        fq.in_pc         = p.pc;
        fq.in_insts      = p.insts;
        fq.in_inst_valid = p.iv;
        fq.in_pred_taken = p.pt;
        fq.in_next_pc    = p.npc;
        fq.out_ready     = deq;
        flush            = fl;
        @(posedge clock);
        #1;
        fq.in_valid  = 1'b0;
        fq.out_ready = 1'b0;
        flush        = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (deq && !was_empty) void'(q.pop_front());
            s = stored(p);
            if (enq && !was_full && s.iv != 4'b0000) q.push_back(s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++; if (fq.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", fq.in_ready); end
        checks++; if (fq.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", fq.out_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (head() !== '0) begin errors++; $display("FAIL reset_out_fields got %h want 0", head()); end
    endtask

    task automatic test_single();
        tick(1, mk(32'h1000, 4'b1111, 4'b0000), 0, 0);
        checks++; if (fq.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", fq.out_valid); end
        checks++; if (fq.out_pc !== 32'h1000) begin errors++; $display("FAIL single_pc got %h want 00001000", fq.out_pc); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        checks++; if (head() !== q[0]) begin errors++; $display("FAIL single_head got %h want %h", head(), q[0]); end
        tick(0, '0, 1, 0);
        checks++; if (fq.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b want 0", fq.out_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_drain_count got %0d want 0", count); end
    endtask

    task automatic test_mask();
        tick(1, mk(32'h2000, 4'b1111, 4'b0110), 0, 0);
        checks++; if (fq.out_inst_valid !== 4'b0011) begin errors++; $display("FAIL mask_iv got %b want 0011", fq.out_inst_valid); end
        checks++; if (fq.out_pred_taken !== 4'b0010) begin errors++; $display("FAIL mask_pt got %b want 0010", fq.out_pred_taken); end
        tick(1, mk(32'h2010, 4'b1010, 4'b0101), 1, 0);
        checks++; if (fq.out_inst_valid !== 4'b1010 || fq.out_pred_taken !== 4'b0000) begin
            errors++; $display("FAIL mask_invalid_taken got iv=%b pt=%b want iv=1010 pt=0000", fq.out_inst_valid, fq.out_pred_taken);
        end
        tick(1, mk(32'h2020, 4'b1110, 4'b1100), 1, 0);
        checks++; if (head() !== q[0]) begin errors++; $display("FAIL mask_head got %h want %h", head(), q[0]); end
        tick(0, '0, 1, 0);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (q.size() > 0 && guard < 40) begin
            checks++; if (fq.out_valid !== 1'b1 || head() !== q[0]) begin
                errors++; $display("FAIL %s_order got v=%b %h want %h", tag, fq.out_valid, head(), q[0]);
            end
            tick(0, '0, 1, 0);
            guard++;
        end
        checks++; if (count !== 4'd0 || fq.out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_empty got count=%0d v=%b want 0 0", tag, count, fq.out_valid);
        end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < DEPTH; i++) tick(1, mk(32'h10 * i, 4'b1111, 4'b0000), 0, 0);
        checks++; if (fq.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", fq.in_ready); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", count); end
        tick(1, mk(32'h999, 4'b1111, 4'b0000), 1, 0);
        checks++; if (count !== 4'd7 || fq.in_ready !== 1'b1) begin
            errors++; $display("FAIL full_enq_deq got count=%0d rdy=%b want 7 1", count, fq.in_ready);
        end
        drain("fill");
        for (int i = 0; i < DEPTH; i++) tick(1, mk(32'h100 + 32'h10 * i, 4'b0111, 4'b0000), 0, 0);
        checks++; if (int'(count) != q.size()) begin errors++; $display("FAIL wrap_count got %0d want %0d", count, q.size()); end
        drain("wrap");
    endtask

    task automatic test_back_to_back();
        tick(1, mk(32'h3000, 4'b1111, 4'b1000), 0, 0);
        for (int i = 1; i < 12; i++) begin
            checks++; if (head() !== q[0] || count !== 4'd1) begin
                errors++; $display("FAIL b2b_%0d got %h c=%0d want %h c=1", i, head(), count, q[0]);
            end
            tick(1, mk(32'h3000 + 32'h10 * i, 4'b1111, 4'b1000), 1, 0);
        end
        drain("b2b");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) tick(1, mk(32'h4000 + 32'h10 * i, 4'b1111, 4'b0000), 0, 0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre_count got %0d want 5", count); end
        tick(1, mk(32'hBAD0, 4'b1111, 4'b0000), 1, 1);
        checks++; if (count !== 4'd0 || fq.out_valid !== 1'b0 || fq.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got c=%0d v=%b r=%b want 0 0 1", count, fq.out_valid, fq.in_ready);
        end
        tick(1, mk(32'h5000, 4'b0011, 4'b0000), 0, 0);
        checks++; if (fq.out_pc !== 32'h5000 || head() !== q[0]) begin
            errors++; $display("FAIL flush_first_pkt got %h want %h", head(), q[0]);
        end
        drain("flush");
    endtask

    task automatic test_zero_lanes();
        checks++; if (fq.in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", fq.in_ready); end
        tick(1, mk(32'h6000, 4'b0000, 4'b0001), 0, 0);
        checks++; if (count !== 4'd0 || fq.out_valid !== 1'b0) begin
            errors++; $display("FAIL zero_lanes got c=%0d v=%b want 0 0", count, fq.out_valid);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) tick(1, mk(32'h7000 + 32'h10 * i, 4'b1111, 4'b0000), 0, 0);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL areset_pre_count got %0d want 3", count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (fq.out_valid !== 1'b0 || count !== 4'd0 || head() !== '0) begin
            errors++; $display("FAIL areset_immediate got v=%b c=%0d want 0 0", fq.out_valid, count);
        end
        #1 reset = 1'b0;
        q.delete();
        tick(1, mk(32'h8000, 4'b0001, 4'b0001), 0, 0);
        checks++; if (fq.out_pc !== 32'h8000 || count !== 4'd1) begin
            errors++; $display("FAIL areset_resume got pc=%h c=%0d want 00008000 1", fq.out_pc, count);
        end
        drain("areset");
    endtask

    initial begin
        fq.in_valid      = 1'b0;
        fq.in_pc         = '0;
        fq.in_insts      = '0;
        fq.in_inst_valid = '0;
        fq.in_pred_taken = '0;
        fq.in_next_pc    = '0;
        fq.out_ready     = 1'b0;
        test_reset();
        test_single();
        test_mask();
        test_fill_wrap();
        test_back_to_back();
        test_flush();
        test_zero_lanes();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
